// File: rtl/cu_dispatcher_pkg.sv
// rtl/cu_dispatcher_pkg.sv - shared types, defaults and width helpers for the CU dispatcher
package cu_dispatcher_pkg;

  localparam int DEF_NUM_CUS          = 4;
  localparam int DEF_THREADS_PER_CU   = 4;
  localparam int DEF_THREAD_CNT_WIDTH = 8;
  localparam int DEF_BLOCK_ID_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Active-thread field must hold the value THREADS_PER_CU itself, hence the +1.
  function automatic int atw_of(input int threads_per_cu);
    return $clog2(threads_per_cu) + 1;
  endfunction

endpackage

// File: rtl/cu_dispatcher_if.sv
// rtl/cu_dispatcher_if.sv - host/CU-side signal bundle for the CU dispatcher
interface cu_dispatcher_if
  import cu_dispatcher_pkg::*;
#(
  parameter int NUM_CUS          = DEF_NUM_CUS,
  parameter int ATW              = atw_of(DEF_THREADS_PER_CU),
  parameter int THREAD_CNT_WIDTH = DEF_THREAD_CNT_WIDTH,
  parameter int BLOCK_ID_WIDTH   = DEF_BLOCK_ID_WIDTH
);

  logic                                     start;
  logic [THREAD_CNT_WIDTH-1:0]              kernel_threads;
  logic                                     busy;
  logic                                     done;
  logic [NUM_CUS-1:0]                       cu_enable;
  logic [NUM_CUS-1:0][ATW-1:0]              cu_active_threads;
  logic [NUM_CUS-1:0][BLOCK_ID_WIDTH-1:0]   cu_block_id;
  logic [NUM_CUS-1:0]                       cu_complete;

  // Host and compute units: drive launch and completion, observe dispatch.
  modport master (
    output start, kernel_threads, cu_complete,
    input  busy, done, cu_enable, cu_active_threads, cu_block_id
  );

  // Dispatcher side.
  modport slave (
    input  start, kernel_threads, cu_complete,
    output busy, done, cu_enable, cu_active_threads, cu_block_id
  );

endinterface

// File: rtl/cu_dispatcher_cu_free_picker.sv
// rtl/cu_dispatcher_cu_free_picker.sv - lowest-index priority encoder over the free-CU mask
module cu_free_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] free_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  // Two's-complement trick isolates the lowest set bit as a one-hot grant.
  assign grant_o = free_i & (~free_i + N'(1));
  assign valid_o = |free_i;

endmodule

// File: rtl/cu_dispatcher.sv
// rtl/cu_dispatcher.sv - splits a kernel into blocks and dispatches them to free CUs; DISPATCH_PERF_EN adds perf counters
module cu_dispatcher
  import cu_dispatcher_pkg::*;
#(
  parameter int NUM_CUS          = DEF_NUM_CUS,
  parameter int THREADS_PER_CU   = DEF_THREADS_PER_CU,
  parameter int THREAD_CNT_WIDTH = DEF_THREAD_CNT_WIDTH,
  parameter int BLOCK_ID_WIDTH   = DEF_BLOCK_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  cu_dispatcher_if.slave            bus
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]               kernel_cycles,
  output logic [BLOCK_ID_WIDTH-1:0] blocks_retired
`endif
);

  localparam int ATW = atw_of(THREADS_PER_CU);
  localparam int CW  = THREAD_CNT_WIDTH;
  localparam int BIW = BLOCK_ID_WIDTH;

  state_e                       state_q, state_d;
  logic [CW-1:0]                total_q, total_d;
  logic [CW-1:0]                next_q, next_d;
  logic [CW-1:0]                kt_q, kt_d;
  logic [NUM_CUS-1:0]           en_q, en_d;
  logic [NUM_CUS-1:0][ATW-1:0]  at_q, at_d;
  logic [NUM_CUS-1:0][BIW-1:0]  bid_q, bid_d;

  logic [NUM_CUS-1:0]           released;
  logic [NUM_CUS-1:0]           grant;
  logic                         grant_vld;
  logic                         more_blocks;
  logic                         last_block;
  logic [CW-1:0]                rem;

  // A released CU still has en_q high this cycle, so ~en_q already excludes it.
  assign released    = en_q & bus.cu_complete;
  assign more_blocks = next_q < total_q;
  assign last_block  = next_q == (total_q - CW'(1));
  assign rem         = kt_q % CW'(THREADS_PER_CU);

  cu_free_picker #(.N(NUM_CUS)) u_picker (
    .free_i  (~en_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  // Next-state: kernel capture, per-cycle single dispatch, release and completion.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    next_d  = next_q;
    kt_d    = kt_q;
    en_d    = en_q;
    at_d    = at_q;
    bid_d   = bid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          kt_d    = bus.kernel_threads;
          next_d  = '0;
          total_d = CW'(({1'b0, bus.kernel_threads} + (CW+1)'(THREADS_PER_CU - 1))
                        / (CW+1)'(THREADS_PER_CU));
        end
      end
      RUN: begin
        en_d = en_q & ~released;
        if (more_blocks && grant_vld) begin
          en_d = en_d | grant;
          for (int i = 0; i < NUM_CUS; i++) begin
            if (grant[i]) begin
              bid_d[i] = BIW'(next_q);
              at_d[i]  = (last_block && rem != '0) ? ATW'(rem) : ATW'(THREADS_PER_CU);
            end
          end
          next_d = next_q + CW'(1);
        end
        if (!more_blocks && en_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and dispatch registers; reset abandons any in-flight kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      total_q <= '0;
      next_q  <= '0;
      kt_q    <= '0;
      en_q    <= '0;
      at_q    <= '0;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      next_q  <= next_d;
      kt_q    <= kt_d;
      en_q    <= en_d;
      at_q    <= at_d;
      bid_q   <= bid_d;
    end
  end

  assign bus.busy              = state_q != IDLE;
  assign bus.done              = state_q == DONE;
  assign bus.cu_enable         = en_q;
  assign bus.cu_active_threads = at_q;
  assign bus.cu_block_id       = bid_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0]  cyc_q, cyc_d;
  logic [BIW-1:0] ret_q, ret_d;

  // Perf counters restart on an accepted launch and hold once the kernel ends.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q == IDLE && bus.start) begin
      cyc_d = '0;
      ret_d = '0;
    end else if (state_q == RUN) begin
      cyc_d = cyc_q + 32'd1;
      ret_d = ret_q + BIW'($countones(released));
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign kernel_cycles  = cyc_q;
  assign blocks_retired = ret_q;
`endif

endmodule

// File: tb/tb_cu_dispatcher.sv
// tb/tb_cu_dispatcher.sv - directed and randomized checks of cu_dispatcher against a behavioural model
module tb_cu_dispatcher;

  localparam int NC  = 4;
  localparam int TPC = 4;
  localparam int TCW = 8;
  localparam int BIW = 8;
  localparam int ATW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cu_dispatcher_if #(.NUM_CUS(NC), .ATW(ATW), .THREAD_CNT_WIDTH(TCW), .BLOCK_ID_WIDTH(BIW)) bus ();

`ifdef DISPATCH_PERF_EN
  logic [31:0]    kernel_cycles;
  logic [BIW-1:0] blocks_retired;
`endif

  cu_dispatcher #(.NUM_CUS(NC), .THREADS_PER_CU(TPC), .THREAD_CNT_WIDTH(TCW), .BLOCK_ID_WIDTH(BIW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DISPATCH_PERF_EN
    ,
    .kernel_cycles  (kernel_cycles),
    .blocks_retired (blocks_retired)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: kernel phase (0 idle, 1 running, 2 finished) and per-CU block assignment.
  int m_st, m_total, m_next, m_kt, m_cyc, m_ret;
  int m_en [NC];
  int m_bid[NC];
  int m_at [NC];
  int age  [NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_total = 0; m_next = 0; m_kt = 0; m_cyc = 0; m_ret = 0;
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 0; m_bid[i] = 0; m_at[i] = 0; age[i] = 0;
    end
  endtask

  task automatic model_edge();
    int pick;
    int any_en;
    any_en = 0;
    for (int i = 0; i < NC; i++) any_en += m_en[i];
    case (m_st)
      0: if (bus.start) begin
        m_st = 1; m_kt = int'(bus.kernel_threads);
        m_total = (m_kt + TPC - 1) / TPC; m_next = 0; m_cyc = 0; m_ret = 0;
      end
      1: begin
        m_cyc++;
        if (m_next == m_total && any_en == 0) m_st = 2;
        pick = -1;
        if (m_next < m_total)
          for (int i = NC - 1; i >= 0; i--) if (m_en[i] == 0) pick = i;
        for (int i = 0; i < NC; i++)
          if (m_en[i] != 0 && bus.cu_complete[i]) begin m_en[i] = 0; m_ret++; end
        if (pick >= 0) begin
          m_en[pick]  = 1;
          m_bid[pick] = m_next;
          m_at[pick]  = (m_next == m_total - 1 && m_kt % TPC != 0) ? m_kt % TPC : TPC;
          m_next++;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all();
    chk("busy", bus.busy, m_st != 0);
    chk("done", bus.done, m_st == 2);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("cu_enable[%0d]", i), bus.cu_enable[i], m_en[i]);
      chk($sformatf("cu_block_id[%0d]", i), bus.cu_block_id[i], m_bid[i]);
      chk($sformatf("cu_active_threads[%0d]", i), bus.cu_active_threads[i], m_at[i]);
    end
`ifdef DISPATCH_PERF_EN
    chk("kernel_cycles", kernel_cycles, m_cyc);
    chk("blocks_retired", blocks_retired, m_ret % 256);
`endif
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    for (int i = 0; i < NC; i++) age[i] = (m_en[i] != 0) ? age[i] + 1 : 0;
  endtask

  // mode 0: random completions and stray starts; mode 1: each CU completes 5 cycles after dispatch.
  task automatic run_kernel(input int kt, input int mode, output int run_cycles);
    int guard;
    int pulses;
    guard = 0; pulses = 0; run_cycles = 0;
    bus.kernel_threads = TCW'(kt);
    bus.start = 1'b1;
    bus.cu_complete = '0;
    cyc();
    bus.start = 1'b0;
    if (bus.busy && !bus.done) run_cycles++;
    while (m_st != 0 && guard < 3000) begin
      if (mode == 0) begin
        bus.start          = ($urandom_range(0, 3) == 0);
        bus.kernel_threads = TCW'($urandom);
        bus.cu_complete    = NC'($urandom_range(0, 15));
      end else begin
        for (int i = 0; i < NC; i++) bus.cu_complete[i] = (m_en[i] != 0 && age[i] >= 5);
      end
      cyc();
      if (bus.done) pulses++;
      if (bus.busy && !bus.done) run_cycles++;
      guard++;
    end
    bus.start = 1'b0;
    bus.cu_complete = '0;
    chk("kernel_terminates", guard < 3000, 1);
    chk("done_pulses", pulses, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    m_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.kernel_threads = '0;
    bus.cu_complete = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // kt=16: four consecutive dispatches, joint completion, done two edges later
    bus.kernel_threads = 8'd16; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc(); chk("s16_en_c1", bus.cu_enable, 4'b0001);
    cyc(); chk("s16_en_c2", bus.cu_enable, 4'b0011);
    cyc(); chk("s16_en_c3", bus.cu_enable, 4'b0111);
    cyc(); chk("s16_en_c4", bus.cu_enable, 4'b1111);
    chk("s16_bid", bus.cu_block_id, 32'h03020100);
    chk("s16_at", bus.cu_active_threads, 12'o4444);
    cyc(); chk("s16_hold", bus.cu_enable, 4'b1111);
    bus.cu_complete = 4'hF;
    cyc(); chk("s16_release", bus.cu_enable, 4'b0000); chk("s16_done_early", bus.done, 0);
    bus.cu_complete = 4'h0;
    cyc(); chk("s16_done", bus.done, 1);
    cyc(); chk("s16_idle", bus.busy, 0);

    // kt=10: three blocks, the last carrying two threads
    bus.kernel_threads = 8'd10; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (5) cyc();
    chk("s10_en", bus.cu_enable, 4'b0111);
    chk("s10_at2", bus.cu_active_threads[2], 2);
    chk("s10_at0", bus.cu_active_threads[0], 4);
    bus.cu_complete = 4'b0111;
    cyc(); chk("s10_cu3_never", bus.cu_enable[3], 0);
    bus.cu_complete = 4'b0000;
    cyc(); chk("s10_done", bus.done, 1);
    cyc();

    // kt=24: re-dispatch after release, concurrent completion and dispatch
    bus.kernel_threads = 8'd24; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (4) cyc();
    bus.cu_complete = 4'b0011;
    cyc(); chk("s24_gap", bus.cu_enable, 4'b1100);
    bus.cu_complete = 4'b1000;
    cyc(); chk("s24_both", bus.cu_enable, 4'b0101);
    chk("s24_bid0", bus.cu_block_id[0], 4);
    chk("s24_bid3_hold", bus.cu_block_id[3], 3);
    bus.cu_complete = 4'b0000;
    cyc(); chk("s24_blk5", bus.cu_enable, 4'b0111);
    chk("s24_bid1", bus.cu_block_id[1], 5);
    bus.cu_complete = 4'b0111;
    cyc();
    bus.cu_complete = 4'b0000;
    cyc(); chk("s24_done", bus.done, 1);
    cyc();

    // kt=0: straight through RUN to DONE
    bus.kernel_threads = 8'd0; bus.start = 1'b1;
    cyc(); chk("s0_run", bus.busy, 1);
    bus.start = 1'b0;
    cyc(); chk("s0_done", bus.done, 1); chk("s0_no_en", bus.cu_enable, 4'b0000);
    cyc();

    // reset mid-RUN with three CUs active
    bus.kernel_threads = 8'd16; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    chk("srst_pre", bus.cu_enable, 4'b0111);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("srst_en", bus.cu_enable, 0);
    chk("srst_busy", bus.busy, 0);
    chk("srst_done", bus.done, 0);
    chk("srst_bid", bus.cu_block_id, 0);
    chk("srst_at", bus.cu_active_threads, 0);
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    run_kernel(4, 0, rc);

    // fixed 5-cycle completion latency, with perf counters when present
    run_kernel(8, 1, rc);
`ifdef DISPATCH_PERF_EN
    chk("perf_retired", blocks_retired, 2);
    chk("perf_cycles", kernel_cycles, rc);
`endif

    // randomized kernels with random completions and ignored stray starts
    for (int k = 0; k < 20; k++) run_kernel($urandom_range(0, 60), 0, rc);
    run_kernel(255, 0, rc);
    run_kernel($urandom_range(1, 40), 1, rc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cu_dispatcher.md
CU_DISPATCHER -- requirements
Module: cu_dispatcher

Interface
REQ-001 Parameter NUM_CUS, default 4: number of compute units driven.
REQ-002 Parameter THREADS_PER_CU, default 4: maximum threads per block, one block per CU.
REQ-003 Parameter THREAD_CNT_WIDTH, default 8: width of the kernel thread count.
REQ-004 Parameter BLOCK_ID_WIDTH, default 8: width of the block index.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1: asynchronous, active-low reset.
REQ-007 Port start  input  1: launches a kernel when sampled high in IDLE.
REQ-008 Port kernel_threads  input  THREAD_CNT_WIDTH: total threads; captured on the accepted start.
REQ-009 Port busy  output  1: high in RUN and DONE.
REQ-010 Port done  output  1: one-cycle pulse when the kernel finishes.
REQ-011 Port cu_enable  output  NUM_CUS: per-CU enable, held high while a block runs on that CU.
REQ-012 Port cu_active_threads  output  NUM_CUS x ATW: thread count of the block on each CU; ATW = $clog2(THREADS_PER_CU)+1.
REQ-013 Port cu_block_id  output  NUM_CUS x BLOCK_ID_WIDTH: index of the block on each CU.
REQ-014 Port cu_complete  input  NUM_CUS: per-CU completion level from each CU.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE when all blocks are dispatched and every cu_enable is low.
- DONE->IDLE unconditionally after one cycle.
REQ-016 On start, total_blocks SHALL be captured as ceil(kernel_threads/THREADS_PER_CU) and the next-block counter cleared.
- The block counter and total_blocks are wide enough for the maximum block count.
REQ-017 In RUN, at most one block SHALL be dispatched per cycle, to the lowest-indexed CU that is free.
- Free means cu_enable is low and the CU was not released that same cycle.
REQ-018 Dispatch SHALL take effect on the next edge, on the dispatched CU only:
- cu_enable goes high.
- cu_block_id takes the block index.
- cu_active_threads is THREADS_PER_CU, or kernel_threads mod THREADS_PER_CU (if nonzero) for the last block.
REQ-019 cu_complete SHALL be honoured only while that CU's cu_enable is high.
- It clears cu_enable on the next edge.
- The CU is not re-dispatched until the following cycle, giving a minimum one-cycle enable-low gap.
REQ-020 Completion on one CU and dispatch to another in the same cycle SHALL both take effect.
REQ-021 done SHALL be high for exactly the single cycle spent in DONE.
REQ-022 start SHALL be ignored while busy is high.
REQ-023 kernel_threads = 0 SHALL go IDLE->RUN->DONE with no cu_enable asserted.
- done is high in the third cycle after start is sampled.
REQ-024 cu_block_id and cu_active_threads SHALL hold their last values while cu_enable is low.

Reset
REQ-025 Asserting reset (low) SHALL immediately set, asynchronously:
- FSM to IDLE.
- busy, done, cu_enable and all counters to 0.
- cu_active_threads and cu_block_id to 0.
REQ-026 Reset mid-kernel SHALL abandon all in-flight blocks, with no done pulse.

Configuration
REQ-027 With DISPATCH_PERF_EN defined, the module SHALL add:
- Output kernel_cycles (32 bits): cleared on the accepted start, incremented every cycle in RUN, held through DONE/IDLE until the next start.
- Output blocks_retired (BLOCK_ID_WIDTH bits): counts honoured completions, cleared on start.
REQ-028 Without DISPATCH_PERF_EN, neither port nor its logic SHALL exist, and behaviour SHALL be otherwise identical.

Structure
REQ-029 A shared package SHALL hold:
- The FSM state enum (IDLE, RUN, DONE).
- The ATW derivation.
- The default parameter constants.
REQ-030 One sub-module, cu_free_picker, SHALL be a parameterised lowest-index priority encoder.
- Input: free mask. Outputs: one-hot grant and valid.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- kernel_threads=16, NUM_CUS=4, TPC=4: CUs 0..3 enabled over 4 consecutive cycles with block_id 0..3 and active_threads 4; all complete together; done 2 cycles after completion.
- kernel_threads=10: 3 blocks; CU2 gets active_threads=2; CU3 never enabled.
- kernel_threads=24: blocks 4,5 go to CU0 and CU1 after their completions, with a one-cycle enable-low gap; CU3 completes in the same cycle block 4 dispatches, and both effects are seen.
- kernel_threads=0: done in the third cycle after start; no cu_enable.
- Reset low mid-RUN with 3 CUs enabled: all outputs 0 at once; a later start=1 with kernel_threads=4 runs cleanly.
- DISPATCH_PERF_EN build with kernel_threads=8 and completions 5 cycles after each dispatch: blocks_retired=2 and kernel_cycles equals the measured RUN cycle count.
